// File: rtl/uart_echo_pkg.sv
// Shared drain-FSM state codes and ASCII constants for the UART echo FIFO.
package uart_echo_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_LOAD       = 2'd1;
  localparam state_t ST_WAIT_START = 2'd2;
  localparam state_t ST_WAIT_DONE  = 2'd3;

  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

endpackage

// File: rtl/uart_echo_fifo_mem.sv
// WIDTH x 2**DEPTH_LOG2 word store with pointers, registered level and flags.
// Push is dropped only when full without a same-cycle pop; rd_dat always shows the head word.
module uart_echo_fifo_mem
  import uart_echo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_vld,
  input  logic [WIDTH-1:0]      push_dat,
  input  logic                  pop_vld,
  output logic [WIDTH-1:0]      rd_dat,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  wr_en;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push_vld && (!full_q || pop_vld);
  assign drop  = push_vld && full_q && !pop_vld;

  always_comb begin
    wr_ptr_d = wr_en   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_vld ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en, pop_vld})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    empty_d = (level_d == '0);
    full_d  = (level_d == LVL_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat;
  end

  assign rd_dat = mem_q[rd_ptr_q];
  assign level  = level_q;
  assign empty  = empty_q;
  assign full   = full_q;

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART loopback: queue received words, drain them to the transmitter under a txbusy handshake.
// Optional UART_ECHO_UPCASE_EN folds lowercase ASCII to uppercase at pop time (WIDTH==8 only).
module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_valid,
  input  logic [WIDTH-1:0]    rx_data,
  input  logic                tx_busy,
  output logic                tx_load,
  output logic [WIDTH-1:0]    tx_data,
  output logic [DEPTH_LOG2:0] level,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                timeout,
  input  logic                clr_status
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_load_q, tx_load_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;
  logic             pop, to_evt, drop;
  logic [WIDTH-1:0] rd_dat, pop_word;

  uart_echo_fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (rx_valid),
    .push_dat (rx_data),
    .pop_vld  (pop),
    .rd_dat   (rd_dat),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .drop     (drop)
  );

`ifdef UART_ECHO_UPCASE_EN
  always_comb begin
    pop_word = rd_dat;
    if (WIDTH == 8 && rd_dat >= WIDTH'(ASCII_LC_A) && rd_dat <= WIDTH'(ASCII_LC_Z))
      pop_word = rd_dat - WIDTH'(CASE_OFFSET);
  end
`else
  assign pop_word = rd_dat;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    to_evt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = pop_word;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Transmitter never acknowledged: treat the word as sent.
          to_evt  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    tx_load_d  = (state_d == ST_LOAD);
    overflow_d = drop   || (overflow_q && !clr_status);
    timeout_d  = to_evt || (timeout_q  && !clr_status);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_load_q  <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_load_q  <= tx_load_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_load  = tx_load_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: queue-level reference model compared every cycle, plus directed literal pins.
module tb_uart_echo_fifo;

  localparam int W     = 8;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int BT    = 15;

  localparam int M_AUTO = 0, M_HI = 1, M_LO = 2, M_LONG = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [W-1:0]  rx_data = '0;
  logic          tx_busy = 1'b0;
  logic          clr_status = 1'b0;
  logic          tx_load;
  logic [W-1:0]  tx_data;
  logic [DL:0]   level;
  logic          empty, full, overflow, timeout;

  always #5 clk = ~clk;

  uart_echo_fifo #(
    .WIDTH        (W),
    .DEPTH_LOG2   (DL),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .timeout    (timeout),
    .clr_status (clr_status)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus the drain stage (0 idle, 1 load, 2 awaiting busy, 3 busy).
  logic [W-1:0] mq[$];
  int           m_ph = 0;
  int           m_wait = 0;
  logic [W-1:0] m_txd = '0;
  logic         m_ovf = 1'b0, m_to = 1'b0;
  bit           m_pop, m_acc, m_ovf_ev, m_to_ev;

  function automatic logic [W-1:0] expect_word(input logic [W-1:0] w);
`ifdef UART_ECHO_UPCASE_EN
    if (w >= 8'h61 && w <= 8'h7A) return w - 8'h20;
`endif
    return w;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ph = 0; m_wait = 0; m_txd = '0; m_ovf = 1'b0; m_to = 1'b0;
    end else begin
      m_pop    = (m_ph == 0) && (mq.size() > 0) && !tx_busy;
      m_acc    = rx_valid && (mq.size() < DEPTH || m_pop);
      m_ovf_ev = rx_valid && !m_acc;
      m_to_ev  = 1'b0;
      case (m_ph)
        0: if (m_pop) begin m_txd = expect_word(mq.pop_front()); m_ph = 1; end
        1: begin m_ph = 2; m_wait = 0; end
        2: begin
          if (tx_busy) m_ph = 3;
          else begin
            m_wait++;
            if (m_wait == BT) begin m_to_ev = 1'b1; m_ph = 0; end
          end
        end
        default: if (!tx_busy) m_ph = 0;
      endcase
      if (m_acc) mq.push_back(rx_data);
      m_ovf = m_ovf_ev || (m_ovf && !clr_status);
      m_to  = m_to_ev  || (m_to  && !clr_status);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("m_level",    level,    mq.size());
    chk("m_empty",    empty,    mq.size() == 0);
    chk("m_full",     full,     mq.size() == DEPTH);
    chk("m_overflow", overflow, m_ovf);
    chk("m_timeout",  timeout,  m_to);
    chk("m_tx_load",  tx_load,  m_ph == 1);
    chk("m_tx_data",  tx_data,  m_txd);
  end

  // Transmitter stand-in and load monitor, driven from the stimulus process only.
  int           mode = M_AUTO;
  bit           armed = 0, long_hi = 0;
  int           b_wait = 0, b_len = 0;
  logic [W-1:0] seen[$];

  task automatic step();
    @(negedge clk);
    if (tx_load) seen.push_back(tx_data);
    if (mode != M_AUTO) armed = 0;
    if (mode != M_LONG) long_hi = 0;
    case (mode)
      M_HI: tx_busy = 1'b1;
      M_LO: tx_busy = 1'b0;
      M_LONG: begin
        if (tx_load) long_hi = 1;
        tx_busy = long_hi;
      end
      default: begin
        if (tx_load) begin
          armed = 1; b_wait = $urandom_range(0, 2); b_len = $urandom_range(1, 8);
        end
        if (armed && b_wait > 0) begin
          b_wait--; tx_busy = 1'b0;
        end else if (armed && b_len > 0) begin
          b_len--; tx_busy = 1'b1;
        end else begin
          armed = 0; tx_busy = 1'b0;
        end
      end
    endcase
  endtask

  task automatic push(input logic [W-1:0] d);
    step();
    rx_valid = 1'b1;
    rx_data  = d;
  endtask

  task automatic drain();
    bit done = 0;
    mode = M_AUTO;
    for (int i = 0; i < 3000 && !done; i++) begin
      step();
      rx_valid = 1'b0;
      clr_status = 1'b0;
      if (empty && !tx_load && m_ph == 0 && mq.size() == 0 && !tx_busy) done = 1;
    end
    chk("drain_done", done, 1);
  endtask

  int sz;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_to", timeout, 0);
    chk("rst_load", tx_load, 0);
    chk("rst_data", tx_data, 0);
    rst_n = 1'b1;

    // Single byte and two-cycle latency
    push(8'h41);
    step(); rx_valid = 1'b0;
    chk("lat_n1_load", tx_load, 0);
    step();
    chk("lat_n2_load", tx_load, 1);
    chk("lat_n2_data", tx_data, 8'h41);
    drain();
    chk("single_level", level, 0);
    chk("single_count", seen.size(), 1);
    seen.delete();

    // Burst fill, overflow, clear, then push in the pop cycle of a full FIFO
    mode = M_HI;
    for (int i = 0; i < 16; i++) push(8'(i));
    step(); rx_valid = 1'b0;
    chk("burst_full", full, 1);
    chk("burst_level", level, 16);
    chk("burst_ovf", overflow, 0);
    push(8'hAA);
    step(); rx_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 16);
    step(); clr_status = 1'b1;
    step(); clr_status = 1'b0;
    chk("ovf_clr", overflow, 0);
    mode = M_AUTO;
    push(8'h55);
    step(); rx_valid = 1'b0;
    chk("fp_level", level, 16);
    chk("fp_ovf", overflow, 0);
    chk("fp_load", tx_load, 1);
    drain();
    chk("order_count", seen.size(), 17);
    if (seen.size() == 17) begin
      for (int i = 0; i < 16; i++) chk("order_word", seen[i], i);
      chk("order_last", seen[16], 8'h55);
    end
    seen.delete();

    // Timeout: transmitter never goes busy
    mode = M_LO;
    push(8'h31);
    step(); rx_valid = 1'b0;
    step();
    chk("to_load", tx_load, 1);
    repeat (15) step();
    chk("to_before", timeout, 0);
    step();
    chk("to_after", timeout, 1);
    chk("to_noload", tx_load, 0);
    mode = M_AUTO;
    push(8'h32);
    drain();
    chk("to_count", seen.size(), 2);
    if (seen.size() == 2) chk("to_second", seen[1], 8'h32);
    step(); clr_status = 1'b1;
    step(); clr_status = 1'b0;
    chk("to_clr", timeout, 0);

    // Randomized traffic
    seen.delete();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 5))
          0: mode = M_HI;
          1: mode = M_LO;
          default: mode = M_AUTO;
        endcase
      end
      step();
      rx_valid   = ($urandom_range(0, 2) == 0);
      rx_data    = 8'($urandom);
      clr_status = ($urandom_range(0, 19) == 0);
    end
    drain();

    // Reset in WAIT_DONE with three words queued
    mode = M_HI;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    step(); rx_valid = 1'b0;
    mode = M_LONG;
    repeat (4) step();
    chk("mid_level", level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_load", tx_load, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_ovf", overflow, 0);
    step();
    step(); rst_n = 1'b1;
    mode = M_AUTO;
    sz = seen.size();
    repeat (30) step();
    chk("mid_no_load", seen.size(), sz);

`ifdef UART_ECHO_UPCASE_EN
    seen.delete();
    push(8'h61);
    push(8'h7B);
    drain();
    chk("up_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("up_a", seen[0], 8'h41);
      chk("up_brace", seen[1], 8'h7B);
    end
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
